spi_word_assembler: RTL and testbench

//  Parametrised successor to the SPI listener. Gathers bytes from the SPI slave

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_fifo.sv | 74 +++++++
 rtl/spi_word_assembler.sv | 154 +++++++++++++++
 tb/tb_spi_word_assembler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI word path.
// Byte width, debug counter width and assembler state codes.
package spi_pkg;

  localparam int BYTE_W = 8;
  localparam int TCNT_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PUSH    = 2'd2;

  // Counter width that stays >= 1 even for n == 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Show-ahead synchronous FIFO for assembled words.
// A push into a full FIFO is taken only when a pop frees the head slot.
module spi_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  import spi_pkg::*;

  localparam int PTR_W = cnt_w(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rptr_q];
  assign level   = level_q;

  // Next storage, pointers and exact occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Register FIFO state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/spi_word_assembler.sv
// Packs SPI bytes into words and queues them for the command logic.
// Partial words are dropped after an idle timeout.
module spi_word_assembler #(
  parameter int BYTES_PER_WORD   = 3,
  parameter int TIMEOUT_CYCLES   = 2000,
  parameter int FIFO_DEPTH       = 4,
  parameter int IRQ_PULSE_CYCLES = 1,
  parameter int MSB_FIRST        = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spi_slave_data_valid,
  input  logic [7:0]                      spi_slave_byte,
  output logic [8*BYTES_PER_WORD-1:0]     spi_data,
  output logic                            spi_data_valid,
  input  logic                            spi_data_ready,
  output logic                            spi_listener_interrupt,
  output logic                            frame_error,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     timeout_cnt
);
  import spi_pkg::*;

  localparam int W     = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W = cnt_w(BYTES_PER_WORD);
  localparam int IRQ_W = cnt_w(IRQ_PULSE_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [IRQ_W-1:0]  irq_q, irq_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  lane;
  logic              last;
  logic              expired;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic              full;
  logic              empty;

  assign last    = (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign expired = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
  assign push    = (state_q == ST_PUSH);
  assign pop     = spi_data_ready && !empty;
  assign push_ok = push && (!full || pop);

  // Byte lane for the current slot, honouring byte order.
  always_comb begin
    lane = byte_cnt_q;
    if (MSB_FIRST != 0) begin
      lane = CNT_W'(BYTES_PER_WORD - 1) - byte_cnt_q;
    end
  end

  // Assembler FSM: collect bytes, hand a full word to the FIFO.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ferr_d     = 1'b0;
    if (spi_slave_data_valid) begin
      if (byte_cnt_q == '0) begin
        shift_d = '0;
      end
      shift_d[lane*BYTE_W +: BYTE_W] = spi_slave_byte;
      if (last) begin
        state_d    = ST_PUSH;
        byte_cnt_d = '0;
      end else begin
        state_d    = ST_COLLECT;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_PUSH: state_d = ST_IDLE;
        ST_COLLECT: begin
          if (expired) begin
            state_d    = ST_IDLE;
            byte_cnt_d = '0;
            ferr_d     = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Idle counter inside a partial word, saturating.
  always_comb begin
    tcnt_d = '0;
    if (!spi_slave_data_valid &&
        state_q == ST_COLLECT && !expired) begin
      tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
    end
  end

  // IRQ stretcher restarts on every accepted push; overflow flag.
  always_comb begin
    ovf_d = push && full && !pop;
    irq_d = '0;
    if (push_ok) begin
      irq_d = IRQ_W'(IRQ_PULSE_CYCLES);
    end else if (irq_q != '0) begin
      irq_d = irq_q - 1'b1;
    end
  end

  // Register assembler state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tcnt_q     <= '0;
      irq_q      <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tcnt_q     <= tcnt_d;
      irq_q      <= irq_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  spi_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (shift_q),
    .rdata (spi_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign spi_data_valid         = !empty;
  assign spi_listener_interrupt = (irq_q != '0);
  assign frame_error            = ferr_q;
  assign overflow               = ovf_q;
  assign timeout_cnt            = tcnt_q;

endmodule

// File: tb/tb_spi_word_assembler.sv
// Bench for spi_word_assembler: two configurations share stimulus,
// each checked every cycle against a queue-based word model.
module tb_spi_word_assembler;

  logic        clk;
  logic        rst;
  logic        strb;
  logic [7:0]  byt;
  logic        rdy;

  logic [23:0] data0;
  logic        valid0, irq0, ferr0, ovf0;
  logic [2:0]  level0;
  logic [15:0] tcnt0;
  logic [31:0] data1;
  logic        valid1, irq1, ferr1, ovf1;
  logic [1:0]  level1;
  logic [15:0] tcnt1;

  int nvec = 0;
  int nerr = 0;
  int n_ovf0 = 0;
  int n_ferr0 = 0;

  spi_word_assembler dut0 (
    .clk(clk), .rst(rst),
    .spi_slave_data_valid(strb), .spi_slave_byte(byt),
    .spi_data(data0), .spi_data_valid(valid0),
    .spi_data_ready(rdy), .spi_listener_interrupt(irq0),
    .frame_error(ferr0), .overflow(ovf0),
    .fifo_level(level0), .timeout_cnt(tcnt0)
  );

  spi_word_assembler #(
    .BYTES_PER_WORD(4), .TIMEOUT_CYCLES(9), .FIFO_DEPTH(2),
    .IRQ_PULSE_CYCLES(3), .MSB_FIRST(0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .spi_slave_data_valid(strb), .spi_slave_byte(byt),
    .spi_data(data1), .spi_data_valid(valid1),
    .spi_data_ready(rdy), .spi_listener_interrupt(irq1),
    .frame_error(ferr1), .overflow(ovf1),
    .fifo_level(level1), .timeout_cnt(tcnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, one slot per configuration.
  int pB[2] = '{3, 4};
  int pT[2] = '{2000, 9};
  int pD[2] = '{4, 2};
  int pP[2] = '{1, 3};
  int pM[2] = '{1, 0};

  logic [7:0]  pb[2][4];
  int          nb[2];
  int          tc[2];
  bit          pend[2];
  logic [31:0] pw[2];
  logic [31:0] fm[2][4];
  int          fl[2];
  int          irem[2];
  bit          eferr[2];
  bit          eovf[2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit pop_m;
      bit acc_m;
      logic [31:0] w;
      if (rst) begin
        nb[i] = 0; tc[i] = 0; pend[i] = 0; fl[i] = 0;
        irem[i] = 0; eferr[i] = 0; eovf[i] = 0;
      end else begin
        pop_m = rdy && (fl[i] > 0);
        acc_m = pend[i] && ((fl[i] < pD[i]) || pop_m);
        eovf[i] = pend[i] && !acc_m;
        if (pop_m) begin
          for (int j = 0; j < 3; j++) fm[i][j] = fm[i][j+1];
          fl[i]--;
        end
        if (acc_m) begin
          fm[i][fl[i]] = pw[i];
          fl[i]++;
        end
        if (acc_m) irem[i] = pP[i];
        else if (irem[i] > 0) irem[i]--;
        eferr[i] = 0;
        pend[i] = 0;
        if (strb) begin
          pb[i][nb[i]] = byt;
          nb[i]++;
          tc[i] = 0;
          if (nb[i] == pB[i]) begin
            w = '0;
            for (int j = 0; j < pB[i]; j++) begin
              if (pM[i] != 0) w[(pB[i]-1-j)*8 +: 8] = pb[i][j];
              else w[j*8 +: 8] = pb[i][j];
            end
            pw[i] = w;
            pend[i] = 1;
            nb[i] = 0;
          end
        end else if (nb[i] > 0) begin
          if (tc[i] == pT[i] - 1) begin
            nb[i] = 0; tc[i] = 0; eferr[i] = 1;
          end else begin
            tc[i]++;
          end
        end else begin
          tc[i] = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare of both DUTs against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("d0.data", {8'h0, data0}, fl[0] > 0 ? {8'h0, fm[0][0][23:0]} : 0);
      chk("d0.valid", {31'h0, valid0}, {31'h0, fl[0] > 0});
      chk("d0.level", {29'h0, level0}, fl[0]);
      chk("d0.irq", {31'h0, irq0}, {31'h0, irem[0] > 0});
      chk("d0.ferr", {31'h0, ferr0}, {31'h0, eferr[0]});
      chk("d0.ovf", {31'h0, ovf0}, {31'h0, eovf[0]});
      chk("d0.tcnt", {16'h0, tcnt0}, tc[0]);
      chk("d1.data", data1, fl[1] > 0 ? fm[1][0] : 0);
      chk("d1.valid", {31'h0, valid1}, {31'h0, fl[1] > 0});
      chk("d1.level", {30'h0, level1}, fl[1]);
      chk("d1.irq", {31'h0, irq1}, {31'h0, irem[1] > 0});
      chk("d1.ferr", {31'h0, ferr1}, {31'h0, eferr[1]});
      chk("d1.ovf", {31'h0, ovf1}, {31'h0, eovf[1]});
      chk("d1.tcnt", {16'h0, tcnt1}, tc[1]);
      if (ovf0) n_ovf0++;
      if (ferr0) n_ferr0++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    strb = 1'b1;
    byt  = b;
    idle(1);
    strb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [23:0] exp);
    chk(nm, {8'h0, data0}, {8'h0, exp});
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
  endtask

  initial begin
    int hits;
    int at;
    logic [23:0] ew;
    rst = 1'b1; strb = 1'b0; byt = 8'h00; rdy = 1'b0;
    idle(2);
    chk("rst.valid", {31'h0, valid0}, 0);
    chk("rst.data", {8'h0, data0}, 0);
    chk("rst.level", {29'h0, level0}, 0);
    rst = 1'b0;
    idle(1);

    // 1: spaced bytes form one word
    send(8'h00); idle(9); send(8'h00); idle(9); send(8'h02);
    idle(1);
    chk("t1.data", {8'h0, data0}, 32'h000002);
    chk("t1.valid", {31'h0, valid0}, 1);
    chk("t1.irq", {31'h0, irq0}, 1);
    chk("t1.level", {29'h0, level0}, 1);
    idle(1);
    chk("t1.irq_end", {31'h0, irq0}, 0);

    // 2: timeout drops partial word
    do_reset();
    send(8'hAB); send(8'hCD);
    hits = 0; at = 0;
    for (int n = 1; n <= 2100; n++) begin
      idle(1);
      if (ferr0) begin hits++; at = n; end
    end
    chk("t2.ferr_cnt", hits, 1);
    chk("t2.ferr_at", at, 2000);
    chk("t2.level", {29'h0, level0}, 0);
    send(8'h12); send(8'h34); send(8'h56); idle(1);
    chk("t2.data", {8'h0, data0}, 32'h123456);

    // 3: overflow on fifth word, drain in order
    do_reset();
    n_ovf0 = 0;
    for (int j = 1; j <= 15; j++) send(8'(j));
    idle(2);
    chk("t3.ovf_cnt", n_ovf0, 1);
    chk("t3.level", {29'h0, level0}, 4);
    for (int w = 0; w < 4; w++) begin
      ew = {8'(3*w+1), 8'(3*w+2), 8'(3*w+3)};
      pop_chk("t3.drain", ew);
    end
    chk("t3.empty", {29'h0, level0}, 0);

    // 4: push while full with simultaneous pop
    do_reset();
    n_ovf0 = 0;
    for (int j = 1; j <= 12; j++) send(8'(j));
    idle(1);
    send(8'hC0); send(8'hFF); send(8'hEE);
    rdy = 1'b1; idle(1); rdy = 1'b0;
    idle(1);
    chk("t4.ovf_cnt", n_ovf0, 0);
    chk("t4.level", {29'h0, level0}, 4);
    pop_chk("t4.q1", 24'h040506);
    pop_chk("t4.q2", 24'h070809);
    pop_chk("t4.q3", 24'h0A0B0C);
    pop_chk("t4.tail", 24'hC0FFEE);

    // 5: strobe exactly at the last idle count wins
    do_reset();
    n_ferr0 = 0;
    send(8'h5A); send(8'h5B);
    idle(1999);
    chk("t5.tcnt", {16'h0, tcnt0}, 1999);
    send(8'h5C); idle(1);
    chk("t5.ferr_cnt", n_ferr0, 0);
    chk("t5.data", {8'h0, data0}, 32'h5A5B5C);
    send(8'hA1); send(8'hA2);
    rst = 1'b1; idle(1);
    chk("t5.rst_data", {8'h0, data0}, 0);
    chk("t5.rst_valid", {31'h0, valid0}, 0);
    chk("t5.rst_level", {29'h0, level0}, 0);
    chk("t5.rst_tcnt", {16'h0, tcnt0}, 0);
    rst = 1'b0;
    send(8'hB1); send(8'hB2); send(8'hB3); idle(1);
    chk("t5.clean", {8'h0, data0}, 32'hB1B2B3);
    chk("t5.ferr_cnt2", n_ferr0, 0);

    // 6: LSB-first 4-byte word; full-rate stream
    do_reset();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); idle(1);
    chk("t6.lsb", data1, 32'h44332211);
    do_reset();
    for (int j = 0; j < 12; j++) send(8'(8'h20 + j));
    idle(1);
    chk("t6.level", {29'h0, level0}, 4);
    for (int w = 0; w < 4; w++) begin
      ew = {8'(32+3*w), 8'(33+3*w), 8'(34+3*w)};
      pop_chk("t6.stream", ew);
    end

    // Randomised traffic
    repeat (300) begin
      int len;
      int gap;
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        strb = ($urandom_range(0, 3) != 0);
        byt  = 8'($urandom);
        rdy  = ($urandom_range(0, 2) == 0);
        idle(1);
      end
      strb = 1'b0;
      gap = $urandom_range(0, 12);
      for (int j = 0; j < gap; j++) begin
        rdy = ($urandom_range(0, 2) == 0);
        idle(1);
      end
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; idle(1); rst = 1'b0;
      end
    end
    rdy = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
